// File: rtl/harness_pkg.sv
// Shared types and constants for the RV64 run controller and its dump sequencer.
package harness_pkg;

    localparam int DEFAULT_XLEN = 64;
    localparam int DEFAULT_ILEN = 32;

    // All-zero instruction word used as the end-of-program marker.
    localparam logic [31:0] HALT_NOP = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN      = 3'd2,
        ST_DUMP_REG = 3'd3,
        ST_DUMP_MEM = 3'd4,
        ST_DONE     = 3'd5
    } harness_state_t;

    function automatic logic can_start(input harness_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/harness_dump_seq.sv
// Indexed valid/ready sequencer: walks index 0..COUNT-1 once per handshake and
// presents the caller's combinational read data as the stream payload.
module harness_dump_seq #(
    parameter int COUNT   = 32,
    parameter int IW      = 5,
    parameter int DW      = 64,
    parameter bit LAST_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_active,
    input  logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [IW-1:0] o_index,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic          o_finish
);

    logic [IW-1:0] r_index;
    logic          w_at_end;
    logic          w_fire;

    assign w_at_end = (r_index == IW'(COUNT - 1));
    assign w_fire   = i_active && i_ready;

    // Index only moves on a handshake, so a stalled beat keeps its address and data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index <= '0;
        end else if (i_clear) begin
            r_index <= '0;
        end else if (w_fire) begin
            r_index <= w_at_end ? '0 : r_index + IW'(1);
        end
    end

    assign o_valid  = i_active;
    assign o_index  = r_index;
    assign o_data   = i_data;
    assign o_last   = LAST_EN && i_active && w_at_end;
    assign o_finish = w_fire && w_at_end;

endmodule

// File: rtl/cpu_test_harness.sv
// Run controller for the sequential RV64 core: load program, run to halt or
// timeout, then stream out the register file followed by a data-memory window.
module cpu_test_harness
    import harness_pkg::*;
#(
    parameter int  XLEN       = DEFAULT_XLEN,
    parameter int  ILEN       = DEFAULT_ILEN,
    parameter int  IMEM_DEPTH = 32,
    parameter int  NREGS      = 32,
    parameter int  DMEM_DUMP  = 32,
    parameter int  TIMEOUT    = 1024,
    parameter logic [ILEN-1:0] HALT_WORD = ILEN'(HALT_NOP),
    localparam int IAW        = $clog2(IMEM_DEPTH),
    localparam int DAW        = $clog2(DMEM_DUMP)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,

    input  logic            load_valid,
    output logic            load_ready,
    input  logic [ILEN-1:0] load_data,
    input  logic            load_last,

    output logic            imem_we,
    output logic [IAW-1:0]  imem_waddr,
    output logic [ILEN-1:0] imem_wdata,

    output logic            cpu_reset,
    output logic            cpu_en,
    input  logic [ILEN-1:0] cpu_instruction,
    input  logic [XLEN-1:0] cpu_pc,

    output logic [4:0]      dbg_reg_addr,
    input  logic [XLEN-1:0] dbg_reg_data,
    output logic [DAW-1:0]  dbg_mem_addr,
    input  logic [XLEN-1:0] dbg_mem_data,

    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_last,

    output logic            done,
    output logic            timed_out,
    output logic [31:0]     cycle_count,
    output logic [XLEN-1:0] halt_pc
);

    harness_state_t r_state;
    harness_state_t w_state_next;

    logic [IAW-1:0]  r_load_ptr;
    logic [IAW-1:0]  w_load_ptr_next;
    logic [31:0]     r_cycle_count;
    logic [31:0]     w_cycle_count_next;
    logic [31:0]     w_cycle_inc;
    logic            r_done;
    logic            w_done_next;
    logic            r_timed_out;
    logic            w_timed_out_next;
    logic [XLEN-1:0] r_halt_pc;
    logic [XLEN-1:0] w_halt_pc_next;

    logic            w_restart;
    logic            w_reg_active;
    logic            w_mem_active;
    logic            w_reg_valid;
    logic            w_mem_valid;
    logic [4:0]      w_reg_idx;
    logic [DAW-1:0]  w_mem_idx;
    logic [XLEN-1:0] w_reg_data;
    logic [XLEN-1:0] w_mem_data;
    logic            w_reg_last;
    logic            w_mem_last;
    logic            w_reg_finish;
    logic            w_mem_finish;

    // Sequencer controls come straight from the state register to keep them
    // outside the next-state process and free of combinational feedback.
    assign w_restart    = can_start(r_state) && start;
    assign w_reg_active = (r_state == ST_DUMP_REG);
    assign w_mem_active = (r_state == ST_DUMP_MEM);
    assign w_cycle_inc  = r_cycle_count + 32'd1;

    harness_dump_seq #(
        .COUNT   (NREGS),
        .IW      (5),
        .DW      (XLEN),
        .LAST_EN (1'b0)
    ) u_reg_seq (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_restart),
        .i_active (w_reg_active),
        .i_ready  (dump_ready),
        .i_data   (dbg_reg_data),
        .o_valid  (w_reg_valid),
        .o_index  (w_reg_idx),
        .o_data   (w_reg_data),
        .o_last   (w_reg_last),
        .o_finish (w_reg_finish)
    );

    harness_dump_seq #(
        .COUNT   (DMEM_DUMP),
        .IW      (DAW),
        .DW      (XLEN),
        .LAST_EN (1'b1)
    ) u_mem_seq (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_restart),
        .i_active (w_mem_active),
        .i_ready  (dump_ready),
        .i_data   (dbg_mem_data),
        .o_valid  (w_mem_valid),
        .o_index  (w_mem_idx),
        .o_data   (w_mem_data),
        .o_last   (w_mem_last),
        .o_finish (w_mem_finish)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_load_ptr    <= '0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_timed_out   <= 1'b0;
            r_halt_pc     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_load_ptr    <= w_load_ptr_next;
            r_cycle_count <= w_cycle_count_next;
            r_done        <= w_done_next;
            r_timed_out   <= w_timed_out_next;
            r_halt_pc     <= w_halt_pc_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_load_ptr_next    = r_load_ptr;
        w_cycle_count_next = r_cycle_count;
        w_done_next        = r_done;
        w_timed_out_next   = r_timed_out;
        w_halt_pc_next     = r_halt_pc;

        cpu_reset  = 1'b1;
        cpu_en     = 1'b0;
        load_ready = 1'b0;
        imem_we    = 1'b0;
        imem_waddr = r_load_ptr;
        imem_wdata = load_data;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                // Core stays frozen (not reset) in DONE so its state can be re-dumped externally.
                cpu_reset = (r_state == ST_IDLE);
                if (start) begin
                    w_state_next       = ST_LOAD;
                    w_load_ptr_next    = '0;
                    w_cycle_count_next = '0;
                    w_done_next        = 1'b0;
                    w_timed_out_next   = 1'b0;
                    w_halt_pc_next     = '0;
                end
            end

            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    imem_we         = 1'b1;
                    w_load_ptr_next = r_load_ptr + IAW'(1);
                    if (load_last || (r_load_ptr == IAW'(IMEM_DEPTH - 1))) begin
                        w_state_next = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                cpu_reset = 1'b0;
                if (cpu_instruction == HALT_WORD) begin
                    // Halt has priority over a coinciding timeout and gates the core this cycle.
                    w_halt_pc_next = cpu_pc;
                    w_state_next   = ST_DUMP_REG;
                end else begin
                    cpu_en = 1'b1;
                    if (r_cycle_count != 32'(TIMEOUT)) begin
                        w_cycle_count_next = w_cycle_inc;
                    end
                    if (w_cycle_inc == 32'(TIMEOUT)) begin
                        w_timed_out_next = 1'b1;
                        w_halt_pc_next   = cpu_pc;
                        w_state_next     = ST_DUMP_REG;
                    end
                end
            end

            ST_DUMP_REG: begin
                cpu_reset = 1'b0;
                if (w_reg_finish) begin
                    w_state_next = ST_DUMP_MEM;
                end
            end

            ST_DUMP_MEM: begin
                cpu_reset = 1'b0;
                if (w_mem_finish) begin
                    w_state_next = ST_DONE;
                    w_done_next  = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign dbg_reg_addr = w_reg_idx;
    assign dbg_mem_addr = w_mem_idx;
    assign dump_valid   = w_reg_valid || w_mem_valid;
    assign dump_data    = w_reg_valid ? w_reg_data : w_mem_data;
    assign dump_last    = w_reg_last || w_mem_last;

    assign done        = r_done;
    assign timed_out   = r_timed_out;
    assign cycle_count = r_cycle_count;
    assign halt_pc     = r_halt_pc;

endmodule

// File: tb/tb_cpu_test_harness.sv
// Scoreboard bench for cpu_test_harness with a small RV64 (addi/add/sub/beq) core stand-in.
module tb_cpu_test_harness;

    localparam int XLEN       = 64;
    localparam int ILEN       = 32;
    localparam int IMEM_DEPTH = 32;
    localparam int IAW        = 5;
    localparam int NREGS      = 32;
    localparam int DMEM_DUMP  = 32;
    localparam int DAW        = 5;
    localparam int TIMEOUT    = 16;
    localparam int NBEATS     = NREGS + DMEM_DUMP;

    logic            clk;
    logic            reset;
    logic            start;
    logic            load_valid;
    logic            load_ready;
    logic [ILEN-1:0] load_data;
    logic            load_last;
    logic            imem_we;
    logic [IAW-1:0]  imem_waddr;
    logic [ILEN-1:0] imem_wdata;
    logic            cpu_reset;
    logic            cpu_en;
    logic [ILEN-1:0] cpu_instruction;
    logic [XLEN-1:0] cpu_pc;
    logic [4:0]      dbg_reg_addr;
    logic [XLEN-1:0] dbg_reg_data;
    logic [DAW-1:0]  dbg_mem_addr;
    logic [XLEN-1:0] dbg_mem_data;
    logic            dump_valid;
    logic            dump_ready;
    logic [XLEN-1:0] dump_data;
    logic            dump_last;
    logic            done;
    logic            timed_out;
    logic [31:0]     cycle_count;
    logic [XLEN-1:0] halt_pc;

    cpu_test_harness #(
        .XLEN       (XLEN),
        .ILEN       (ILEN),
        .IMEM_DEPTH (IMEM_DEPTH),
        .NREGS      (NREGS),
        .DMEM_DUMP  (DMEM_DUMP),
        .TIMEOUT    (TIMEOUT),
        .HALT_WORD  (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_data       (load_data),
        .load_last       (load_last),
        .imem_we         (imem_we),
        .imem_waddr      (imem_waddr),
        .imem_wdata      (imem_wdata),
        .cpu_reset       (cpu_reset),
        .cpu_en          (cpu_en),
        .cpu_instruction (cpu_instruction),
        .cpu_pc          (cpu_pc),
        .dbg_reg_addr    (dbg_reg_addr),
        .dbg_reg_data    (dbg_reg_data),
        .dbg_mem_addr    (dbg_mem_addr),
        .dbg_mem_data    (dbg_mem_data),
        .dump_valid      (dump_valid),
        .dump_ready      (dump_ready),
        .dump_data       (dump_data),
        .dump_last       (dump_last),
        .done            (done),
        .timed_out       (timed_out),
        .cycle_count     (cycle_count),
        .halt_pc         (halt_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction semantics shared by core stand-in and reference
    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] val;
        logic [63:0] npc;
    } step_t;

    function automatic step_t iss_step(input logic [31:0] ins, input logic [63:0] a,
                                       input logic [63:0] b, input logic [63:0] pc);
        step_t s;
        s.we  = 1'b0;
        s.rd  = ins[11:7];
        s.val = '0;
        s.npc = pc + 64'd4;
        case (ins[6:0])
            7'b0010011: if (ins[14:12] == 3'b000) begin
                s.we  = 1'b1;
                s.val = a + {{52{ins[31]}}, ins[31:20]};
            end
            7'b0110011: if (ins[14:12] == 3'b000) begin
                s.we  = 1'b1;
                s.val = ins[30] ? a - b : a + b;
            end
            7'b1100011: if (ins[14:12] == 3'b000 && a == b) begin
                s.npc = pc + {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            default: ;
        endcase
        if (s.rd == 5'd0) s.we = 1'b0;
        return s;
    endfunction

    // ---------------- core stand-in driven by the harness
    logic [31:0] core_imem [IMEM_DEPTH];
    logic [63:0] core_regs [NREGS];
    logic [63:0] dmem      [DMEM_DUMP];
    logic [63:0] core_pc;
    step_t       core_step;

    assign cpu_instruction = core_imem[core_pc[6:2]];
    assign cpu_pc          = core_pc;
    assign dbg_reg_data    = core_regs[dbg_reg_addr];
    assign dbg_mem_data    = dmem[dbg_mem_addr];
    assign core_step       = iss_step(cpu_instruction, core_regs[cpu_instruction[19:15]],
                                      core_regs[cpu_instruction[24:20]], core_pc);

    always @(posedge clk) begin
        if (imem_we) core_imem[imem_waddr] <= imem_wdata;
        if (cpu_reset) begin
            core_pc <= '0;
            for (int i = 0; i < NREGS; i++) core_regs[i] <= '0;
        end else if (cpu_en) begin
            if (core_step.we) core_regs[core_step.rd] <= core_step.val;
            core_pc <= core_step.npc;
        end
    end

    // ---------------- scoreboard
    typedef struct packed { logic [63:0] data; logic last; } beat_t;
    typedef struct packed { logic to; logic [31:0] cc; logic [63:0] hpc; } stat_t;

    beat_t       exp_q [$];
    stat_t       st_q  [$];
    logic [31:0] ref_imem [IMEM_DEPTH];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: run the loaded program instruction by instruction until the
    // halt word or the cycle budget, then list the expected dump.
    task automatic ref_run();
        logic [63:0] r [NREGS];
        logic [63:0] pc;
        int          cnt;
        logic        to;
        logic [63:0] hpc;
        logic [31:0] ins;
        step_t       s;
        beat_t       b;
        stat_t       st;
        for (int i = 0; i < NREGS; i++) r[i] = '0;
        pc = '0; cnt = 0; to = 1'b0; hpc = '0;
        for (int k = 0; k <= TIMEOUT; k++) begin
            ins = ref_imem[pc[6:2]];
            if (ins == 32'h0) begin
                hpc = pc;
                break;
            end
            s = iss_step(ins, r[ins[19:15]], r[ins[24:20]], pc);
            if (s.we) r[s.rd] = s.val;
            cnt++;
            if (cnt == TIMEOUT) begin
                to  = 1'b1;
                hpc = pc;
                break;
            end
            pc = s.npc;
        end
        for (int i = 0; i < NBEATS; i++) begin
            b.data = (i < NREGS) ? r[i] : dmem[i - NREGS];
            b.last = (i == NBEATS - 1);
            exp_q.push_back(b);
        end
        st.to = to; st.cc = 32'(cnt); st.hpc = hpc;
        st_q.push_back(st);
    endtask

    // ---------------- monitor
    logic [63:0] cap      [NBEATS];
    logic        cap_last [NBEATS];
    logic [63:0] golden   [NBEATS];
    logic [4:0]  we_addr  [64];
    int          cap_n    = 0;
    int          beat_cnt = 0;
    int          we_n     = 0;

    initial begin
        logic        stall_prev;
        logic [63:0] held_data;
        logic        held_last;
        logic        prev_done;
        beat_t       e;
        stat_t       st;
        stall_prev = 1'b0; prev_done = 1'b0; held_data = '0; held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", {63'd0, dump_valid}, 64'd1);
                    chk("hold_data", dump_data, held_data);
                    chk("hold_last", {63'd0, dump_last}, {63'd0, held_last});
                end
                if (dump_valid && dump_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL extra_beat: got %0h expected no beat", dump_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dump_data", dump_data, e.data);
                        chk("dump_last", {63'd0, dump_last}, {63'd0, e.last});
                    end
                    if (cap_n < NBEATS) begin
                        cap[cap_n]      = dump_data;
                        cap_last[cap_n] = dump_last;
                    end
                    cap_n++;
                    beat_cnt++;
                end
                stall_prev = dump_valid && !dump_ready;
                held_data  = dump_data;
                held_last  = dump_last;
                if (imem_we) begin
                    if (we_n < 64) we_addr[we_n] = imem_waddr;
                    we_n++;
                end
                if (done && !prev_done) begin
                    if (st_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL extra_done: got done=1 expected no completion");
                    end else begin
                        st = st_q.pop_front();
                        chk("timed_out", {63'd0, timed_out}, {63'd0, st.to});
                        chk("cycle_count", {32'd0, cycle_count}, {32'd0, st.cc});
                        chk("halt_pc", halt_pc, st.hpc);
                    end
                end
                prev_done = done;
            end
        end
    end

    // ---------------- dump_ready driver: 0 always ready, 1 alternating with stalls, 2 stop at a beat count
    int rmode   = 0;
    int stop_at = 0;
    initial begin
        bit tog;
        tog = 1'b0;
        dump_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin
                    dump_ready = tog ? ($urandom_range(0, 3) != 0) : 1'b0;
                    tog = ~tog;
                end
                2:       dump_ready = (beat_cnt < stop_at);
                default: dump_ready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus helpers
    logic [31:0] prog_w [64];
    int          prog_n;

    function automatic logic [31:0] rand_alu();
        logic [4:0] rd, rs1, rs2;
        rd  = 5'($urandom_range(1, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 2) != 0) return {12'($urandom), rs1, 3'b000, rd, 7'b0010011};
        return {1'b0, 1'($urandom), 5'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic do_start();
        cap_n = 0; beat_cnt = 0; we_n = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic load_prog(input bit mark_last, output int accepted);
        bit ok;
        accepted = 0;
        for (int i = 0; i < prog_n; i++) begin
            load_valid = 1'b1;
            load_data  = prog_w[i];
            load_last  = mark_last && (i == prog_n - 1);
            ok = 1'b0;
            for (int t = 0; t < 4; t++) begin
                @(negedge clk);
                if (load_ready) begin ok = 1'b1; break; end
            end
            if (ok) begin
                @(posedge clk); #1;
                ref_imem[i % IMEM_DEPTH] = prog_w[i];
                accepted++;
                if (load_last || i == IMEM_DEPTH - 1) ref_run();
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_reached", {63'd0, done}, 64'd1);
        @(negedge clk);
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        chk("beat_total", 64'(cap_n), 64'(NBEATS));
    endtask

    task automatic set_default_prog();
        prog_w[0] = 32'h00F00093;
        prog_w[1] = 32'h01900113;
        prog_w[2] = 32'h002082B3;
        prog_w[3] = 32'h00000000;
        prog_n = 4;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence
    initial begin
        int acc;
        int nlast;
        reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            core_imem[i] = '0;
            ref_imem[i]  = '0;
        end
        for (int i = 0; i < NREGS; i++) core_regs[i] = '0;
        for (int i = 0; i < DMEM_DUMP; i++) dmem[i] = {$urandom, $urandom};
        core_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        chk("rst_cpu_en", {63'd0, cpu_en}, 64'd0);
        chk("rst_load_ready", {63'd0, load_ready}, 64'd0);
        chk("rst_imem_we", {63'd0, imem_we}, 64'd0);
        chk("rst_dump_valid", {63'd0, dump_valid}, 64'd0);
        chk("rst_dump_last", {63'd0, dump_last}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_timed_out", {63'd0, timed_out}, 64'd0);
        chk("rst_cycle_count", {32'd0, cycle_count}, 64'd0);
        chk("rst_halt_pc", halt_pc, 64'd0);
        reset = 1'b0;

        // Default program, unstalled
        set_default_prog();
        rmode = 0;
        do_start();
        load_prog(1'b1, acc);
        wait_done();
        chk("dflt_cycles", {32'd0, cycle_count}, 64'd3);
        chk("dflt_halt_pc", halt_pc, 64'hC);
        chk("dflt_timed_out", {63'd0, timed_out}, 64'd0);
        chk("dflt_beat1", cap[1], 64'd15);
        chk("dflt_beat2", cap[2], 64'd25);
        chk("dflt_beat5", cap[5], 64'd40);
        nlast = 0;
        for (int i = 0; i < NBEATS; i++) nlast += int'(cap_last[i]);
        chk("dflt_last_count", 64'(nlast), 64'd1);
        chk("dflt_last_pos", {63'd0, cap_last[NBEATS-1]}, 64'd1);
        for (int i = 0; i < NBEATS; i++) golden[i] = cap[i];

        // Immediate halt
        prog_w[0] = 32'h0; prog_n = 1;
        do_start();
        load_prog(1'b1, acc);
        wait_done();
        chk("imm_cycles", {32'd0, cycle_count}, 64'd0);
        chk("imm_halt_pc", halt_pc, 64'd0);
        for (int i = 0; i < NREGS; i++) chk("imm_reg_zero", cap[i], 64'd0);

        // Timeout on a branch-to-self loop
        prog_w[0] = 32'h00000063; prog_w[1] = 32'h0; prog_n = 2;
        do_start();
        load_prog(1'b1, acc);
        wait_done();
        chk("to_flag", {63'd0, timed_out}, 64'd1);
        chk("to_cycles", {32'd0, cycle_count}, 64'(TIMEOUT));
        chk("to_halt_pc", halt_pc, 64'd0);

        // Overflow: more words than the memory holds, no load_last
        for (int i = 0; i < IMEM_DEPTH + 2; i++) prog_w[i] = rand_alu();
        prog_n = IMEM_DEPTH + 2;
        do_start();
        load_prog(1'b0, acc);
        chk("ovf_accepted", 64'(acc), 64'(IMEM_DEPTH));
        chk("ovf_load_ready", {63'd0, load_ready}, 64'd0);
        wait_done();
        chk("ovf_we_pulses", 64'(we_n), 64'(IMEM_DEPTH));
        for (int i = 0; i < IMEM_DEPTH; i++) chk("ovf_we_addr", {59'd0, we_addr[i]}, 64'(i));

        // Backpressure must reproduce the unstalled default dump
        set_default_prog();
        for (int i = 0; i < IMEM_DEPTH; i++) ref_imem[i] = (i < 4) ? prog_w[i] : ref_imem[i];
        rmode = 1;
        do_start();
        load_prog(1'b1, acc);
        wait_done();
        for (int i = 0; i < NBEATS; i++) chk("bp_vs_golden", cap[i], golden[i]);

        // Random programs, mixed ready patterns
        for (int r = 0; r < 6; r++) begin
            prog_n = $urandom_range(2, 9);
            for (int i = 0; i < prog_n; i++) prog_w[i] = rand_alu();
            if ($urandom_range(0, 3) != 0) prog_w[prog_n-1] = 32'h0;
            rmode = $urandom_range(0, 1);
            do_start();
            load_prog(1'b1, acc);
            wait_done();
        end

        // Reset while DUMP_MEM sits at index 5, then reload and redo
        set_default_prog();
        stop_at = NREGS + 5;
        rmode   = 2;
        do_start();
        load_prog(1'b1, acc);
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (beat_cnt >= stop_at) break;
        end
        @(negedge clk);
        chk("mid_mem_index", {59'd0, dbg_mem_addr}, 64'd5);
        chk("mid_valid", {63'd0, dump_valid}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_dump_valid", {63'd0, dump_valid}, 64'd0);
        chk("arst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        chk("arst_load_ready", {63'd0, load_ready}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        exp_q.delete();
        st_q.delete();
        rmode = 0;
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        do_start();
        load_prog(1'b1, acc);
        wait_done();
        for (int i = 0; i < NBEATS; i++) chk("rerun_vs_golden", cap[i], golden[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
